// File: rtl/pong_pkg.sv
// Shared Pong constants: VGA 640x480@60 timing, object dimensions, reset
// positions, position payload type and the rectangle hit-test helper.
// Imported by the renderer, its timing generator and the game-logic stage.
package pong_pkg;

  localparam int unsigned H_VIDEO = 640;
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned V_VIDEO = 480;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;

  localparam int unsigned H_TOTAL      = H_VIDEO + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_VIDEO + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_VIDEO + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VIDEO + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int unsigned SQUARE_WIDTH  = 16;
  localparam int unsigned PADDLE_WIDTH  = 12;
  localparam int unsigned PADDLE_HEIGHT = 96;
  localparam int unsigned NET_SIZE      = 12;

  localparam int unsigned NET_LEFT  = H_VIDEO / 2 - 6;
  localparam int unsigned NET_RIGHT = H_VIDEO / 2 + 5;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned NET_CNT_W = 4;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_ext_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  localparam pos_t RST_SQUARE  = '{x: 10'd320, y: 10'd240};
  localparam pos_t RST_PADDLE1 = '{x: 10'd24,  y: 10'd191};
  localparam pos_t RST_PADDLE2 = '{x: 10'd603, y: 10'd191};

  // Rectangle hit test; one extra bit keeps pos + size from wrapping.
  function automatic logic hit(input coord_t h, input coord_t v, input pos_t p,
                               input int unsigned w, input int unsigned ht);
    coord_ext_t h_e, v_e, x_e, y_e;
    h_e = {1'b0, h};
    v_e = {1'b0, v};
    x_e = {1'b0, p.x};
    y_e = {1'b0, p.y};
    return (h_e >= x_e) && (h_e < x_e + coord_ext_t'(w)) &&
           (v_e >= y_e) && (v_e < y_e + coord_ext_t'(ht));
  endfunction

endpackage

// File: rtl/pong_renderer_if.sv
// Game-logic <-> renderer bus: object positions toward the renderer,
// VGA video/sync stream and frame tick back out.
//   master: game/board side (drives positions, receives video)
//   slave : renderer (receives positions, drives video)
interface pong_renderer_if;
  import pong_pkg::*;

  coord_t square_xpos;
  coord_t square_ypos;
  coord_t paddle1_xpos;
  coord_t paddle1_ypos;
  coord_t paddle2_xpos;
  coord_t paddle2_ypos;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   pixel;
  logic   frame_tick;

  modport master (
    output square_xpos, square_ypos, paddle1_xpos, paddle1_ypos,
           paddle2_xpos, paddle2_ypos,
    input  hsync, vsync, video_on, pixel, frame_tick
  );

  modport slave (
    input  square_xpos, square_ypos, paddle1_xpos, paddle1_ypos,
           paddle2_xpos, paddle2_ypos,
    output hsync, vsync, video_on, pixel, frame_tick
  );
endinterface

// File: rtl/vga_timing.sv
// VGA 640x480@60 raster counters with decoded sync/active/strobe terms.
//   clk_0, rst      : pixel clock, synchronous active-high reset
//   hcount, vcount  : registered raster position
//   *_c             : combinational decodes of the current position
module vga_timing
  import pong_pkg::*;
(
  input  logic   clk_0,
  input  logic   rst,
  output coord_t hcount,
  output coord_t vcount,
  output logic   hsync_c,
  output logic   vsync_c,
  output logic   video_on_c,
  output logic   frame_start_c,
  output logic   line_end_c,
  output logic   frame_end_c
);

  // Raster position counters.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (line_end_c) begin
      hcount <= '0;
      vcount <= frame_end_c ? '0 : vcount + coord_t'(1);
    end else begin
      hcount <= hcount + coord_t'(1);
    end
  end

  // Decodes of the current position.
  always_comb begin
    line_end_c    = (hcount == coord_t'(H_TOTAL - 1));
    frame_end_c   = line_end_c && (vcount == coord_t'(V_TOTAL - 1));
    hsync_c       = !((hcount >= coord_t'(H_SYNC_START)) && (hcount < coord_t'(H_SYNC_END)));
    vsync_c       = !((vcount >= coord_t'(V_SYNC_START)) && (vcount < coord_t'(V_SYNC_END)));
    video_on_c    = (hcount < coord_t'(H_VIDEO)) && (vcount < coord_t'(V_VIDEO));
    frame_start_c = (hcount == '0) && (vcount == coord_t'(V_VIDEO));
  end

endmodule

// File: rtl/pong_renderer.sv
// Pong display stage: per-frame position snapshot, dashed net, object hit
// tests and a registered 1-bit pixel stream with aligned VGA syncs.
//   clk_0 : pixel clock (25.175 MHz)
//   rst   : synchronous active-high reset
//   bus   : positions in, hsync/vsync/video_on/pixel/frame_tick out
module pong_renderer
  import pong_pkg::*;
(
  input  logic           clk_0,
  input  logic           rst,
  pong_renderer_if.slave bus
);

  coord_t hcount, vcount;
  logic   hsync_c, vsync_c, video_on_c, frame_start_c, line_end_c, frame_end_c;

  vga_timing u_timing (
    .clk_0         (clk_0),
    .rst           (rst),
    .hcount        (hcount),
    .vcount        (vcount),
    .hsync_c       (hsync_c),
    .vsync_c       (vsync_c),
    .video_on_c    (video_on_c),
    .frame_start_c (frame_start_c),
    .line_end_c    (line_end_c),
    .frame_end_c   (frame_end_c)
  );

  pos_t square_q, paddle1_q, paddle2_q;

  // Shadow positions, refreshed once per frame at the start of vblank.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      square_q  <= RST_SQUARE;
      paddle1_q <= RST_PADDLE1;
      paddle2_q <= RST_PADDLE2;
    end else if (frame_start_c) begin
      square_q  <= '{x: bus.square_xpos,  y: bus.square_ypos};
      paddle1_q <= '{x: bus.paddle1_xpos, y: bus.paddle1_ypos};
      paddle2_q <= '{x: bus.paddle2_xpos, y: bus.paddle2_ypos};
    end
  end

  logic [NET_CNT_W-1:0] net_line;
  logic                 net_on;

  // Net dash phase: toggles every NET_SIZE lines, restarts "on" each frame.
  always_ff @(posedge clk_0) begin
    if (rst || frame_end_c) begin
      net_line <= '0;
      net_on   <= 1'b1;
    end else if (line_end_c) begin
      if (net_line == NET_CNT_W'(NET_SIZE - 1)) begin
        net_line <= '0;
        net_on   <= !net_on;
      end else begin
        net_line <= net_line + NET_CNT_W'(1);
      end
    end
  end

  logic ball_c, pad1_c, pad2_c, net_c, pixel_c;

  // Object coverage at the current raster position.
  always_comb begin
    ball_c  = hit(hcount, vcount, square_q,  SQUARE_WIDTH, SQUARE_WIDTH);
    pad1_c  = hit(hcount, vcount, paddle1_q, PADDLE_WIDTH, PADDLE_HEIGHT);
    pad2_c  = hit(hcount, vcount, paddle2_q, PADDLE_WIDTH, PADDLE_HEIGHT);
    net_c   = net_on && (hcount >= coord_t'(NET_LEFT)) && (hcount <= coord_t'(NET_RIGHT));
    pixel_c = video_on_c && (ball_c || pad1_c || pad2_c || net_c);
  end

  // Output registers: one cycle behind the counters, mutually aligned.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      bus.hsync      <= 1'b1;
      bus.vsync      <= 1'b1;
      bus.video_on   <= 1'b0;
      bus.pixel      <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.hsync      <= hsync_c;
      bus.vsync      <= vsync_c;
      bus.video_on   <= video_on_c;
      bus.pixel      <= pixel_c;
      bus.frame_tick <= frame_start_c;
    end
  end

endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer: reset values, sync widths, net dashes,
// object extents, snapshot timing, mid-frame reset and edge clipping.
module tb_pong_renderer;
  import pong_pkg::*;

  localparam int FRAME = 420000;
  localparam int LINE  = 800;

  logic clk_0 = 1'b0;
  logic rst   = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  pong_renderer_if bus ();

  pong_renderer dut (
    .clk_0 (clk_0),
    .rst   (rst),
    .bus   (bus)
  );

  always #20 clk_0 = ~clk_0;

  // Edges since the last reset edge; output for raster p appears at cyc == p+1.
  always @(posedge clk_0) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the negedge where the output for (fr, v, h) is visible.
  task automatic at(input int fr, input int v, input int h);
    int target;
    target = fr * FRAME + v * LINE + h + 1;
    while (cyc < target) @(negedge clk_0);
  endtask

  task automatic scan_line(input int fr, input int v, output logic [799:0] row,
                           output int hlow, output int vlow, output int von);
    row  = '0;
    hlow = 0;
    vlow = 0;
    von  = 0;
    for (int h = 0; h < LINE; h++) begin
      at(fr, v, h);
      row[h] = bus.pixel;
      if (!bus.hsync)   hlow++;
      if (!bus.vsync)   vlow++;
      if (bus.video_on) von++;
    end
  endtask

  initial begin
    #70000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [799:0] row;
  int hl, vl, vo, vsum;

  initial begin
    bus.square_xpos  = 10'd320;
    bus.square_ypos  = 10'd240;
    bus.paddle1_xpos = 10'd24;
    bus.paddle1_ypos = 10'd191;
    bus.paddle2_xpos = 10'd603;
    bus.paddle2_ypos = 10'd191;

    repeat (2) @(negedge clk_0);
    chk("rst_hsync",    32'(bus.hsync),      32'd1);
    chk("rst_vsync",    32'(bus.vsync),      32'd1);
    chk("rst_video_on", 32'(bus.video_on),   32'd0);
    chk("rst_pixel",    32'(bus.pixel),      32'd0);
    chk("rst_tick",     32'(bus.frame_tick), 32'd0);
    rst = 1'b0;

    // First partial frame, reset-default shadows.
    at(0, 0, 0);
    chk("von_first", 32'(bus.video_on), 32'd1);
    scan_line(0, 0, row, hl, vl, vo);
    chk("l0_hsync_low", 32'(hl), 32'd96);
    chk("l0_video_on",  32'(vo), 32'd640);
    chk("l0_white",     32'($countones(row)), 32'd12);
    chk("net_313", 32'(row[313]), 32'd0);
    chk("net_314", 32'(row[314]), 32'd1);
    chk("net_325", 32'(row[325]), 32'd1);
    chk("net_326", 32'(row[326]), 32'd0);
    scan_line(0, 12, row, hl, vl, vo);
    chk("l12_white", 32'($countones(row)), 32'd0);
    scan_line(0, 24, row, hl, vl, vo);
    chk("l24_white", 32'($countones(row)), 32'd12);
    scan_line(0, 190, row, hl, vl, vo);
    chk("l190_white", 32'($countones(row)), 32'd0);
    scan_line(0, 191, row, hl, vl, vo);
    chk("p1_top_23", 32'(row[23]), 32'd0);
    chk("p1_top_24", 32'(row[24]), 32'd1);
    chk("p1_top_35", 32'(row[35]), 32'd1);
    chk("p1_top_36", 32'(row[36]), 32'd0);
    chk("p2_top_603", 32'(row[603]), 32'd1);
    chk("p2_top_614", 32'(row[614]), 32'd1);
    chk("l191_white", 32'($countones(row)), 32'd24);
    scan_line(0, 239, row, hl, vl, vo);
    chk("l239_white", 32'($countones(row)), 32'd24);
    scan_line(0, 255, row, hl, vl, vo);
    chk("ball_319", 32'(row[319]), 32'd0);
    chk("ball_320", 32'(row[320]), 32'd1);
    chk("ball_335", 32'(row[335]), 32'd1);
    chk("ball_336", 32'(row[336]), 32'd0);
    chk("l255_white", 32'($countones(row)), 32'd40);
    scan_line(0, 256, row, hl, vl, vo);
    chk("l256_white", 32'($countones(row)), 32'd24);
    scan_line(0, 286, row, hl, vl, vo);
    chk("p1_bot_286", 32'(row[24]), 32'd1);
    scan_line(0, 287, row, hl, vl, vo);
    chk("p1_bot_287", 32'(row[24]), 32'd0);
    chk("l287_white", 32'($countones(row)), 32'd0);

    // One-cycle reset in the middle of line 300, inside the hsync pulse.
    at(0, 300, 700);
    chk("pre_rst_hsync", 32'(bus.hsync), 32'd0);
    rst = 1'b1;
    @(negedge clk_0);
    rst = 1'b0;
    chk("mid_rst_hsync",    32'(bus.hsync),      32'd1);
    chk("mid_rst_vsync",    32'(bus.vsync),      32'd1);
    chk("mid_rst_video_on", 32'(bus.video_on),   32'd0);
    chk("mid_rst_pixel",    32'(bus.pixel),      32'd0);
    chk("mid_rst_tick",     32'(bus.frame_tick), 32'd0);
    at(0, 0, 0);
    chk("resume_von",   32'(bus.video_on), 32'd1);
    chk("resume_hsync", 32'(bus.hsync),    32'd1);
    scan_line(0, 0, row, hl, vl, vo);
    chk("resume_hsync_low", 32'(hl), 32'd96);
    chk("resume_white",     32'($countones(row)), 32'd12);
    chk("resume_net_314",   32'(row[314]), 32'd1);

    // Mid-frame move must not reach the current frame.
    at(0, 200, 0);
    bus.square_xpos = 10'd100;
    scan_line(0, 255, row, hl, vl, vo);
    chk("f0_ball_320", 32'(row[320]), 32'd1);
    chk("f0_ball_336", 32'(row[336]), 32'd0);
    chk("f0_ball_100", 32'(row[100]), 32'd0);
    chk("f0_l255_white", 32'($countones(row)), 32'd40);

    at(0, 479, 799);
    chk("tick0_pre", 32'(bus.frame_tick), 32'd0);
    at(0, 480, 0);
    chk("tick0_at_384001", 32'(bus.frame_tick), 32'd1);
    chk("tick0_von",       32'(bus.video_on),   32'd0);
    at(0, 480, 1);
    chk("tick0_post", 32'(bus.frame_tick), 32'd0);

    vsum = 0;
    scan_line(0, 489, row, hl, vl, vo);
    chk("l489_vlow", 32'(vl), 32'd0);
    chk("l489_white", 32'($countones(row)), 32'd0);
    vsum += vl;
    scan_line(0, 490, row, hl, vl, vo);
    vsum += vl;
    scan_line(0, 491, row, hl, vl, vo);
    vsum += vl;
    scan_line(0, 492, row, hl, vl, vo);
    chk("l492_vlow", 32'(vl), 32'd0);
    vsum += vl;
    chk("vsync_low_total", 32'(vsum), 32'd1600);

    at(0, 500, 0);
    bus.square_xpos = 10'd630;
    bus.square_ypos = 10'd470;

    // Frame 1 shows the ball captured at the first snapshot.
    scan_line(1, 255, row, hl, vl, vo);
    chk("f1_ball_99",  32'(row[99]),  32'd0);
    chk("f1_ball_100", 32'(row[100]), 32'd1);
    chk("f1_ball_115", 32'(row[115]), 32'd1);
    chk("f1_ball_116", 32'(row[116]), 32'd0);
    chk("f1_ball_320", 32'(row[320]), 32'd0);
    chk("f1_l255_white", 32'($countones(row)), 32'd40);

    at(1, 479, 799);
    chk("tick1_pre", 32'(bus.frame_tick), 32'd0);
    at(1, 480, 0);
    chk("tick1_at_804001", 32'(bus.frame_tick), 32'd1);

    // Frame 2: ball clipped at the bottom-right corner.
    scan_line(2, 0, row, hl, vl, vo);
    chk("f2_l0_white", 32'($countones(row)), 32'd12);
    chk("f2_l0_col0",  32'(row[0]), 32'd0);
    scan_line(2, 469, row, hl, vl, vo);
    chk("f2_l469_white", 32'($countones(row)), 32'd0);
    scan_line(2, 470, row, hl, vl, vo);
    chk("clip_629", 32'(row[629]), 32'd0);
    chk("clip_630", 32'(row[630]), 32'd1);
    chk("clip_639", 32'(row[639]), 32'd1);
    chk("clip_640", 32'(row[640]), 32'd0);
    chk("clip_l470_white", 32'($countones(row)), 32'd10);
    scan_line(2, 479, row, hl, vl, vo);
    chk("clip_l479_white", 32'($countones(row)), 32'd10);
    scan_line(2, 480, row, hl, vl, vo);
    chk("clip_l480_white", 32'($countones(row)), 32'd0);
    chk("clip_l480_von",   32'(vo), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
